// File: rtl/face_pixel_streamer.sv
// face_pixel_streamer
// Raster-scans one FRAME_W x FRAME_H frame per start pulse, x fastest.
// Pixels inside the centred face window are read from an external greyscale
// ROM (one cycle latency) and widened to RGB565. All other pixels use
// BG_COLOUR. Every pixel follows the same FETCH/WAIT/PRESENT/ADVANCE path,
// so frame timing does not depend on where the window sits.
module face_pixel_streamer #(
  parameter int unsigned FRAME_W   = 240,
  parameter int unsigned FRAME_H   = 320,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned X_OFF     = 88,
  parameter int unsigned Y_OFF     = 128,
  parameter int unsigned ROM_AW    = 12,
  parameter logic [15:0] BG_COLOUR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frameDone,
  output logic [ROM_AW-1:0] romAddr,
  input  logic [7:0]        romData,
  output logic [15:0]       pixel,
  output logic              pixelReady,
  input  logic              pixelAccept
);

  localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_ADVANCE
  } state_t;

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_cnt_reg, x_cnt_next;
  logic [YW-1:0]     y_cnt_reg, y_cnt_next;
  logic [15:0]       pixel_reg, pixel_next;
  logic              frame_done_reg, frame_done_next;

  logic [31:0]       x_ext;
  logic [31:0]       y_ext;
  logic              in_win;
  logic              last_x;
  logic              last_y;
  logic [ROM_AW-1:0] win_addr;
  logic [15:0]       grey_rgb;
  logic              unused_grey_lsbs;

  // Widen the counters once so every window comparison is done in 32 bits.
  assign x_ext = 32'(x_cnt_reg);
  assign y_ext = 32'(y_cnt_reg);

  assign in_win = (x_ext >= X_OFF) && (x_ext < X_OFF + IMG_W) &&
                  (y_ext >= Y_OFF) && (y_ext < Y_OFF + IMG_H);

  assign last_x = (x_ext == FRAME_W - 1);
  assign last_y = (y_ext == FRAME_H - 1);

  // Window-relative linear address, deliberately truncated to the ROM width.
  assign win_addr = ROM_AW'((y_ext - Y_OFF) * IMG_W + (x_ext - X_OFF));

  // Greyscale replicated into the R, G and B fields of RGB565.
  assign grey_rgb = {romData[7:3], romData[7:2], romData[7:3]};

  // The two lowest grey bits have no place in RGB565.
  assign unused_grey_lsbs = &{1'b0, romData[1:0]};

  // State register: reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: scan counters, presented pixel, end-of-frame pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_cnt_reg      <= '0;
      y_cnt_reg      <= '0;
      pixel_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      x_cnt_reg      <= x_cnt_next;
      y_cnt_reg      <= y_cnt_next;
      pixel_reg      <= pixel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state and datapath update for the per-pixel sequence.
  always_comb begin
    state_next      = state_reg;
    x_cnt_next      = x_cnt_reg;
    y_cnt_next      = y_cnt_reg;
    pixel_next      = pixel_reg;
    frame_done_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // A start landing on the frameDone cycle is treated as a leftover
        // request for the frame that just finished and is dropped.
        if (start && !frame_done_reg) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        // romAddr is already driven from the counters during this cycle.
        state_next = S_WAIT;
      end

      S_WAIT: begin
        pixel_next = in_win ? grey_rgb : BG_COLOUR;
        state_next = S_PRESENT;
      end

      S_PRESENT: begin
        if (pixelAccept) begin
          state_next = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        if (!last_x) begin
          x_cnt_next = x_cnt_reg + XW'(1);
          state_next = S_FETCH;
        end else if (!last_y) begin
          x_cnt_next = '0;
          y_cnt_next = y_cnt_reg + YW'(1);
          state_next = S_FETCH;
        end else begin
          // Park on (0,0) with a clean zero pixel so the idle outputs match
          // the post-reset ones.
          x_cnt_next      = '0;
          y_cnt_next      = '0;
          pixel_next      = '0;
          frame_done_next = 1'b1;
          state_next      = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != S_IDLE);
  assign pixelReady = (state_reg == S_PRESENT);
  assign pixel      = pixel_reg;
  assign frameDone  = frame_done_reg;
  assign romAddr    = in_win ? win_addr : '0;

endmodule

// File: doc/face_pixel_streamer.md
# face_pixel_streamer

Upstream pixel source for the LCD input stage. On a start pulse it raster-scans one full 240×320 frame. Pixels inside a centred face window come from an external 8-bit greyscale face-image ROM (the KNN test or matched face) and are expanded to RGB565. All other pixels use a background colour. Each pixel is presented on a valid/accept handshake that drives the display input stage's `pixel`/`pixelReady` pair.

## Interface
Parameters:
- `FRAME_W`, 240: frame width in pixels
- `FRAME_H`, 320: frame height in pixels
- `IMG_W`, 64: face image width
- `IMG_H`, 64: face image height
- `X_OFF`, 88: window left column
- `Y_OFF`, 128: window top row
- `ROM_AW`, 12: ROM address width; 2^ROM_AW ≥ IMG_W·IMG_H
- `BG_COLOUR`, 16'h0000: RGB565 value for pixels outside the window

Ports:
- `clock`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `busy`  out  1  high from the accepted start until frameDone
- `frameDone`  out  1  one-cycle pulse after the last pixel is accepted
- `romAddr`  out  ROM_AW  face ROM address
- `romData`  in  8  greyscale sample, valid 1 cycle after romAddr
- `pixel`  out  16  RGB565 pixel, stable while pixelReady is high
- `pixelReady`  out  1  pixel valid
- `pixelAccept`  in  1  consumer takes the pixel this cycle

## Operation
- Counters: `xCnt` (0..FRAME_W-1) and `yCnt` (0..FRAME_H-1). Scan order is x fastest, starting at (0,0).
- Window test: `inWin = X_OFF ≤ xCnt < X_OFF+IMG_W` and `Y_OFF ≤ yCnt < Y_OFF+IMG_H`.
- ROM address: `romAddr = (yCnt−Y_OFF)·IMG_W + (xCnt−X_OFF)`, truncated to ROM_AW bits. It is 0 when not inWin.
- Colour conversion from greyscale g: `pixel = {g[7:3], g[7:2], g[7:3]}`. When not inWin, `pixel = BG_COLOUR`.
- FSM states:
  - IDLE: outputs quiet. Move to FETCH when `start` is high.
  - FETCH: drive romAddr for the current (x,y). Go to WAIT.
  - WAIT: ROM latency cycle. Register the colour-converted pixel. Go to PRESENT.
  - PRESENT: hold pixelReady=1 with pixel stable. When pixelAccept=1, go to ADVANCE.
  - ADVANCE: step the counters.
    - If x < FRAME_W−1: x+1. Go to FETCH.
    - Else if y < FRAME_H−1: x=0, y+1. Go to FETCH.
    - Else (last pixel): x=0, y=0, pulse frameDone, go to IDLE.
- Every pixel takes the same path, background pixels included. Timing does not depend on pixel position.
- `start` is ignored while busy. A start pulse on the frameDone cycle is also ignored. The next start is honoured from IDLE.
- pixelAccept is ignored outside PRESENT.

## Timing
- Reset (async assert, synchronous release) gives: state IDLE, xCnt=yCnt=0, romAddr=0, pixel=0, pixelReady=0, busy=0, frameDone=0.
- Reset asserted mid-frame aborts the frame immediately. No frameDone is produced. A new start is required after release.
- Start sampled high in IDLE at edge N: busy=1 and FETCH from N+1. pixelReady rises at N+3.
- pixelReady falls on the edge after the accepting edge. The next pixel is presented 3 cycles after that.
- Zero-stall throughput is one pixel per 4 cycles. A full frame is 307200 cycles at minimum.
- Consumer stall: pixelReady and pixel hold indefinitely. No pixel is dropped or repeated.
- frameDone is high during the ADVANCE→IDLE transition cycle after the 76800th accept. busy falls in that same cycle.

## Test plan
- Reset, then a start pulse with pixelAccept tied high. Required:
  - first pixel is 0x0000 at (0,0), pixelReady rising 3 cycles after start;
  - exactly 76800 handshakes;
  - frameDone pulses once;
  - busy low afterwards.
- ROM model returns 0xFF everywhere. Required:
  - pixel (88,128) gives romAddr 0, pixel 0xFFFF;
  - pixel (151,191) gives romAddr 4095, pixel 0xFFFF;
  - pixels (87,128) and (152,191) give 0x0000.
- ROM model returns 0x80. Required: window pixels are 0x8410, and window pixel count is 4096.
- Random pixelAccept stalls of 0–20 cycles. Required: pixel stable while pixelReady is high, and the accepted stream matches the reference raster exactly.
- Reset asserted at handshake 1000. Required: all outputs return to reset values within the same cycle, and no frameDone. Then start again: the first pixel is (0,0).
- Start pulsed repeatedly while busy, and once on the frameDone cycle. Required: only one frame is produced, and the next start after IDLE produces a second frame.
